// File: rtl/tx_ctrl_pkg.sv
// rtl/tx_ctrl_pkg.sv - shared tx_fsm command codes and scheduler state encoding
package tx_ctrl_pkg;

  localparam int WORD_W_DEF = 32;

  localparam logic [1:0] CMD_IDLE = 2'd0;
  localparam logic [1:0] CMD_RX   = 2'd1;
  localparam logic [1:0] CMD_TX   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, search starts at ptr and wraps
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic found;
  int   cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(ptr) + k) % N_REQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        gnt[cand]   = 1'b1;
        gnt_idx     = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/tx_word_scheduler.sv
// rtl/tx_word_scheduler.sv - shares tx_fsm among N_REQ word producers, round-robin
// Define TXSCHED_TIMEOUT_EN to add a WAIT watchdog that aborts with an err pulse.
module tx_word_scheduler
  import tx_ctrl_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int WORD_W         = WORD_W_DEF,
  parameter int START_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int IDX_W         = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*WORD_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        done,
  output logic                    err,
  output logic                    busy,
  output logic [IDX_W-1:0]        grant_id,
  output logic [1:0]              fsm_state_in,
  output logic [WORD_W-1:0]       fsm_transmit_data,
  input  logic                    fsm_finish_fsm
);

  localparam int SC_W = $clog2(START_CYCLES + 1);

  sched_state_t     state;
  logic [IDX_W-1:0] rr_ptr;
  logic [SC_W-1:0]  start_cnt;
  logic [N_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             accept;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Reset must silence req_ready immediately, not only after the state register clears.
  assign req_ready = (rst && state == ST_IDLE) ? arb_gnt : '0;
  assign accept    = |req_ready;

`ifdef TXSCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wait_cnt;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= ST_IDLE;
      rr_ptr            <= '0;
      start_cnt         <= '0;
      done              <= '0;
      busy              <= 1'b0;
      grant_id          <= '0;
      fsm_state_in      <= CMD_IDLE;
      fsm_transmit_data <= '0;
`ifdef TXSCHED_TIMEOUT_EN
      err               <= 1'b0;
      wait_cnt          <= '0;
`endif
    end else begin
      done <= '0;
`ifdef TXSCHED_TIMEOUT_EN
      err  <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (accept) begin
            fsm_transmit_data <= req_data[arb_idx*WORD_W +: WORD_W];
            grant_id          <= arb_idx;
            fsm_state_in      <= CMD_TX;
            start_cnt         <= SC_W'(1);
            busy              <= 1'b1;
            state             <= ST_START;
          end
        end
        ST_START: begin
          if (start_cnt == SC_W'(START_CYCLES)) begin
            fsm_state_in <= CMD_IDLE;
            state        <= ST_WAIT;
`ifdef TXSCHED_TIMEOUT_EN
            wait_cnt     <= '0;
`endif
          end else begin
            start_cnt <= start_cnt + 1'b1;
          end
        end
        ST_WAIT: begin
          // A real finish wins over a watchdog expiry on the same edge.
          if (fsm_finish_fsm) begin
            done[grant_id] <= 1'b1;
            state          <= ST_DONE;
          end
`ifdef TXSCHED_TIMEOUT_EN
          else if (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            done[grant_id] <= 1'b1;
            err            <= 1'b1;
            state          <= ST_DONE;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        ST_DONE: begin
          rr_ptr <= (grant_id == IDX_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
